// File: rtl/ctrl_pipe_hazard_if.sv
// Decoder-to-pipeline control interface for ctrl_pipe_hazard.
// The master side is the decoder/upstream logic. It drives the ID-stage
// bundle and flush, and it consumes stall plus the per-stage controls.
// The slave side is the hazard/pipeline block.
interface ctrl_pipe_hazard_if #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2
);
    // Decoder bundle for the instruction currently in ID
    logic               RegDst;
    logic               Jump;
    logic               Branch;
    logic               MemRead;
    logic               MemtoReg;
    logic               MemWrite;
    logic               ALUSrc;
    logic               RegWrite;
    logic               JAL;
    logic [ALUOP_W-1:0] ALUOp;
    logic [REG_AW-1:0]  id_rs;
    logic [REG_AW-1:0]  id_rt;
    logic [REG_AW-1:0]  id_rd;
    logic               flush;

    // Hazard and stage outputs
    logic               stall;
    logic               ex_ALUSrc;
    logic               ex_RegDst;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic [REG_AW-1:0]  ex_rs;
    logic [REG_AW-1:0]  ex_rt;
    logic               mem_MemRead;
    logic               mem_MemWrite;
    logic               mem_Branch;
    logic               mem_Jump;
    logic               wb_RegWrite;
    logic               wb_MemtoReg;
    logic               wb_JAL;
    logic [REG_AW-1:0]  wb_dst;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;

    modport master (
        output RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc,
               RegWrite, JAL, ALUOp, id_rs, id_rt, id_rd, flush,
        input  stall, ex_ALUSrc, ex_RegDst, ex_ALUOp, ex_rs, ex_rt,
               mem_MemRead, mem_MemWrite, mem_Branch, mem_Jump,
               wb_RegWrite, wb_MemtoReg, wb_JAL, wb_dst, fwd_a, fwd_b
    );

    modport slave (
        input  RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc,
               RegWrite, JAL, ALUOp, id_rs, id_rt, id_rd, flush,
        output stall, ex_ALUSrc, ex_RegDst, ex_ALUOp, ex_rs, ex_rt,
               mem_MemRead, mem_MemWrite, mem_Branch, mem_Jump,
               wb_RegWrite, wb_MemtoReg, wb_JAL, wb_dst, fwd_a, fwd_b
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control-side pipeline for a classic 5-stage core.
// The decoder bundle is carried through the ID/EX, EX/MEM and MEM/WB
// registers. A load-use hazard raises stall and inserts a bubble into EX.
// A taken branch or jump (flush) kills the instructions in ID and EX.
// The EX-stage operand forwarding selects are computed from the registered
// MEM and WB state.
module ctrl_pipe_hazard #(
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 2,
    parameter int LINK_REG = 31
) (
    input logic               CLK,
    input logic               RST,
    ctrl_pipe_hazard_if.slave bus
);

    localparam logic [REG_AW-1:0] LINK_DST = REG_AW'(LINK_REG);

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    // Everything the EX stage needs, plus what travels further down
    typedef struct packed {
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               jump;
        logic               reg_write;
        logic               mem_to_reg;
        logic               jal;
        logic [REG_AW-1:0]  dst;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
    } ex_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              reg_write;
        logic              mem_to_reg;
        logic              jal;
        logic [REG_AW-1:0] dst;
    } mem_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              jal;
        logic [REG_AW-1:0] dst;
    } wb_t;

    ex_t  id_bundle;
    ex_t  ex_q;
    mem_t mem_q;
    wb_t  wb_q;
    logic hazard;

    // Pick the MEM result first and the WB result second. Register 0 is never
    // forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input mem_t              m,
        input wb_t               w
    );
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (m.reg_write && (m.dst != '0) && (m.dst == src)) begin
            sel = FWD_EXMEM;
        end else if (w.reg_write && (w.dst != '0) && (w.dst == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    // Build the EX-stage copy of the ID bundle and resolve the destination
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        id_bundle            = '0;
        id_bundle.alu_src    = bus.ALUSrc;
        id_bundle.reg_dst    = bus.RegDst;
        id_bundle.alu_op     = bus.ALUOp;
        id_bundle.mem_read   = bus.MemRead;
        id_bundle.mem_write  = bus.MemWrite;
        id_bundle.branch     = bus.Branch;
        id_bundle.jump       = bus.Jump;
        id_bundle.reg_write  = bus.RegWrite | bus.JAL;
        id_bundle.mem_to_reg = bus.MemtoReg;
        id_bundle.jal        = bus.JAL;
        id_bundle.rs         = bus.id_rs;
        id_bundle.rt         = bus.id_rt;
        if (bus.JAL) begin
            id_bundle.dst = LINK_DST;
        end else if (bus.RegDst) begin
            id_bundle.dst = bus.id_rd;
        end else begin
            id_bundle.dst = bus.id_rt;
        end
    end

    // Load in EX whose destination is a source of the instruction in ID
    always_comb begin
        hazard = 1'b0;
        if (ex_q.mem_read && (ex_q.dst != '0) &&
            ((ex_q.dst == bus.id_rs) || (ex_q.dst == bus.id_rt))) begin
            hazard = 1'b1;
        end
    end

    // A flush kills the ID instruction anyway, so it also cancels the stall.
    assign bus.stall = hazard & ~bus.flush;

    // ID->EX capture. A stall or a flush inserts a bubble.
    always_ff @(posedge CLK) begin
        // NOTE: stage registers use non-blocking assignments, so each stage samples its predecessor's value from before the edge.
        if (RST) begin
            // NOTE: every stage register is reset, because a stale control bit would commit a write, store or forward after reset.
            ex_q <= '0;
        end else if (bus.flush || hazard) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_bundle;
        end
    end

    // EX->MEM advance. A flush kills the instruction leaving EX.
    always_ff @(posedge CLK) begin
        if (RST || bus.flush) begin
            mem_q <= '0;
        end else begin
            mem_q.mem_read   <= ex_q.mem_read;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.branch     <= ex_q.branch;
            mem_q.jump       <= ex_q.jump;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.mem_to_reg <= ex_q.mem_to_reg;
            mem_q.jal        <= ex_q.jal;
            mem_q.dst        <= ex_q.dst;
        end
    end

    // MEM->WB advance. This stage always advances and is never killed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_q <= '0;
        end else begin
            wb_q.reg_write  <= mem_q.reg_write;
            wb_q.mem_to_reg <= mem_q.mem_to_reg;
            wb_q.jal        <= mem_q.jal;
            wb_q.dst        <= mem_q.dst;
        end
    end

    // Forwarding selects for both EX operands
    always_comb begin
        bus.fwd_a = fwd_sel(ex_q.rs, mem_q, wb_q);
        bus.fwd_b = fwd_sel(ex_q.rt, mem_q, wb_q);
    end

    assign bus.ex_ALUSrc    = ex_q.alu_src;
    assign bus.ex_RegDst    = ex_q.reg_dst;
    assign bus.ex_ALUOp     = ex_q.alu_op;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.mem_MemRead  = mem_q.mem_read;
    assign bus.mem_MemWrite = mem_q.mem_write;
    assign bus.mem_Branch   = mem_q.branch;
    assign bus.mem_Jump     = mem_q.jump;
    assign bus.wb_RegWrite  = wb_q.reg_write;
    assign bus.wb_MemtoReg  = wb_q.mem_to_reg;
    assign bus.wb_JAL       = wb_q.jal;
    assign bus.wb_dst       = wb_q.dst;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Testbench for ctrl_pipe_hazard.
// A reference pipeline of instruction records is advanced once per clock.
// Directed scenarios plus a randomized run are compared against it, and
// against constants for the scenario-specific values.
module tb_ctrl_pipe_hazard;
    localparam int REG_AW   = 5;
    localparam int ALUOP_W  = 2;
    localparam int LINK_REG = 31;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    ctrl_pipe_hazard_if #(.REG_AW(REG_AW), .ALUOP_W(ALUOP_W)) bus ();

    ctrl_pipe_hazard #(
        .REG_AW  (REG_AW),
        .ALUOP_W (ALUOP_W),
        .LINK_REG(LINK_REG)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // Decoder bundle as presented in ID
    typedef struct packed {
        logic       reg_dst, jump, branch, mem_read, mem_to_reg;
        logic       mem_write, alu_src, reg_write, jal;
        logic [1:0] alu_op;
        logic [4:0] rs, rt, rd;
    } in_t;

    // An instruction as the rest of the pipeline sees it
    typedef struct packed {
        logic       alu_src, reg_dst;
        logic [1:0] alu_op;
        logic       mem_read, mem_write, branch, jump, mem_to_reg, writes, jal;
        logic [4:0] dst, rs, rt;
    } instr_t;

    instr_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    in_t    cur;
    logic   cur_flush;
    int     n_vec = 0;
    int     n_bad = 0;

    function automatic in_t mk_nop();
        in_t i;
        i = '0;
        return i;
    endfunction

    function automatic in_t mk_lw(input logic [4:0] rt, input logic [4:0] rs);
        in_t i;
        i = '0;
        i.mem_read = 1'b1; i.mem_to_reg = 1'b1; i.alu_src = 1'b1; i.reg_write = 1'b1;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic in_t mk_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        in_t i;
        i = '0;
        i.reg_dst = 1'b1; i.reg_write = 1'b1; i.alu_op = 2'b10;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic in_t mk_addi(input logic [4:0] rt, input logic [4:0] rs);
        in_t i;
        i = '0;
        i.alu_src = 1'b1; i.reg_write = 1'b1;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic in_t mk_jal();
        in_t i;
        i = '0;
        i.jump = 1'b1; i.jal = 1'b1;   // RegWrite deliberately left 0
        i.rd = 5'd7; i.rt = 5'd6;
        return i;
    endfunction

    // How an ID instruction looks once it has entered the pipeline
    function automatic instr_t enter(input in_t i);
        instr_t d;
        d = '0;
        d.alu_src = i.alu_src;  d.reg_dst = i.reg_dst;  d.alu_op = i.alu_op;
        d.mem_read = i.mem_read; d.mem_write = i.mem_write;
        d.branch = i.branch;    d.jump = i.jump;        d.mem_to_reg = i.mem_to_reg;
        d.jal = i.jal;
        d.writes = i.reg_write | i.jal;
        d.dst = i.jal ? 5'(LINK_REG) : (i.reg_dst ? i.rd : i.rt);
        d.rs = i.rs; d.rt = i.rt;
        return d;
    endfunction

    // True when the ID instruction needs a value still being loaded in EX
    function automatic logic load_use();
        return pipe[0].mem_read && (pipe[0].dst != 5'd0) &&
               ((pipe[0].dst == cur.rs) || (pipe[0].dst == cur.rt));
    endfunction

    // Nearest older producer of register r, as seen from EX
    function automatic logic [1:0] source_of(input logic [4:0] r);
        for (int s = 1; s <= 2; s++) begin
            if (r != 5'd0 && pipe[s].writes && pipe[s].dst == r)
                return (s == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic [30:0] model_vec();
        return {load_use() & ~cur_flush,
                pipe[0].alu_src, pipe[0].reg_dst, pipe[0].alu_op, pipe[0].rs, pipe[0].rt,
                pipe[1].mem_read, pipe[1].mem_write, pipe[1].branch, pipe[1].jump,
                pipe[2].writes, pipe[2].mem_to_reg, pipe[2].jal, pipe[2].dst,
                source_of(pipe[0].rs), source_of(pipe[0].rt)};
    endfunction

    function automatic logic [30:0] dut_vec();
        return {bus.stall, bus.ex_ALUSrc, bus.ex_RegDst, bus.ex_ALUOp, bus.ex_rs, bus.ex_rt,
                bus.mem_MemRead, bus.mem_MemWrite, bus.mem_Branch, bus.mem_Jump,
                bus.wb_RegWrite, bus.wb_MemtoReg, bus.wb_JAL, bus.wb_dst,
                bus.fwd_a, bus.fwd_b};
    endfunction

    task automatic drive(input in_t i, input logic f);
        cur = i;
        cur_flush = f;
        bus.RegDst = i.reg_dst;  bus.Jump = i.jump;         bus.Branch = i.branch;
        bus.MemRead = i.mem_read; bus.MemtoReg = i.mem_to_reg; bus.MemWrite = i.mem_write;
        bus.ALUSrc = i.alu_src;  bus.RegWrite = i.reg_write; bus.JAL = i.jal;
        bus.ALUOp = i.alu_op;
        bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd;
        bus.flush = f;
        #1;
    endtask

    // One clock edge. The reference pipeline moves the same way.
    task automatic cycle();
        instr_t nxt [3];
        if (RST) begin
            nxt[0] = '0; nxt[1] = '0; nxt[2] = '0;
        end else begin
            nxt[2] = pipe[1];
            nxt[1] = cur_flush ? instr_t'('0) : pipe[0];
            nxt[0] = (cur_flush || load_use()) ? instr_t'('0) : enter(cur);
        end
        @(posedge CLK);
        #1;
        pipe = nxt;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(mk_nop(), 1'b0);
        cycle();
        cycle();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        in_t i;
        i = mk_lw(5'd3, 5'd3);
        i.rd = 5'd4;
        RST = 1'b1;
        drive(i, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== 31'd0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc%0d: got %h want 0", k, dut_vec());
            end
        end
        RST = 1'b0;
        cycle();
        n_vec++;
        if ({bus.ex_ALUSrc, bus.ex_rs, bus.ex_rt} !== {1'b1, 5'd3, 5'd3}) begin
            n_bad++;
            $display("FAIL reset_release_ex: got %h want %h",
                     {bus.ex_ALUSrc, bus.ex_rs, bus.ex_rt}, {1'b1, 5'd3, 5'd3});
        end
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL reset_release_model: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(mk_lw(5'd8, 5'd1), 1'b0);
        cycle();
        drive(mk_add(5'd10, 5'd8, 5'd9), 1'b0);
        n_vec++;
        if (bus.stall !== 1'b1) begin
            n_bad++;
            $display("FAIL load_use_stall: got %b want 1", bus.stall);
        end
        cycle();
        n_vec++;
        if ({bus.stall, bus.ex_ALUSrc, bus.ex_RegDst, bus.ex_ALUOp, bus.ex_rs, bus.ex_rt} !== 15'd0) begin
            n_bad++;
            $display("FAIL load_use_bubble: got %h want 0",
                     {bus.stall, bus.ex_ALUSrc, bus.ex_RegDst, bus.ex_ALUOp, bus.ex_rs, bus.ex_rt});
        end
        cycle();
        n_vec++;
        if ({bus.ex_rs, bus.fwd_a, bus.fwd_b} !== {5'd8, 2'b01, 2'b00}) begin
            n_bad++;
            $display("FAIL load_use_fwd: got rs=%0d a=%b b=%b want rs=8 a=01 b=00",
                     bus.ex_rs, bus.fwd_a, bus.fwd_b);
        end
    endtask

    task automatic test_forward();
        do_reset();
        drive(mk_add(5'd9, 5'd1, 5'd2), 1'b0);
        cycle();
        drive(mk_add(5'd3, 5'd9, 5'd9), 1'b0);
        cycle();
        n_vec++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'b1010) begin
            n_bad++;
            $display("FAIL fwd_exmem: got %b%b want 1010", bus.fwd_a, bus.fwd_b);
        end
        drive(mk_add(5'd9, 5'd1, 5'd2), 1'b0);
        cycle();
        drive(mk_nop(), 1'b0);
        cycle();
        drive(mk_add(5'd3, 5'd9, 5'd9), 1'b0);
        cycle();
        n_vec++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'b0101) begin
            n_bad++;
            $display("FAIL fwd_memwb: got %b%b want 0101", bus.fwd_a, bus.fwd_b);
        end
    endtask

    task automatic test_priority();
        do_reset();
        drive(mk_add(5'd5, 5'd1, 5'd2), 1'b0);
        cycle();
        drive(mk_add(5'd5, 5'd3, 5'd4), 1'b0);
        cycle();
        drive(mk_add(5'd7, 5'd5, 5'd6), 1'b0);
        cycle();
        n_vec++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'b1000) begin
            n_bad++;
            $display("FAIL fwd_priority: got %b%b want 1000", bus.fwd_a, bus.fwd_b);
        end
    endtask

    task automatic test_zero_reg();
        in_t seq [4];
        do_reset();
        seq[0] = mk_addi(5'd0, 5'd1);
        seq[1] = mk_add(5'd4, 5'd0, 5'd0);
        seq[2] = mk_lw(5'd0, 5'd2);
        seq[3] = mk_add(5'd4, 5'd0, 5'd0);
        for (int k = 0; k < 6; k++) begin
            drive((k < 4) ? seq[k] : mk_nop(), 1'b0);
            n_vec++;
            if ({bus.stall, bus.fwd_a, bus.fwd_b} !== 5'd0) begin
                n_bad++;
                $display("FAIL zero_reg cyc%0d: got stall=%b a=%b b=%b want 0 00 00",
                         k, bus.stall, bus.fwd_a, bus.fwd_b);
            end
            cycle();
        end
    endtask

    task automatic test_jal_flush();
        do_reset();
        drive(mk_jal(), 1'b0);
        cycle();
        drive(mk_nop(), 1'b0);
        cycle();
        cycle();
        n_vec++;
        if ({bus.wb_JAL, bus.wb_RegWrite, bus.wb_dst} !== {1'b1, 1'b1, 5'd31}) begin
            n_bad++;
            $display("FAIL jal_wb: got jal=%b rw=%b dst=%0d want 1 1 31",
                     bus.wb_JAL, bus.wb_RegWrite, bus.wb_dst);
        end
        drive(mk_lw(5'd8, 5'd1), 1'b0);
        cycle();
        drive(mk_add(5'd10, 5'd8, 5'd9), 1'b1);
        n_vec++;
        if (bus.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_stall: got %b want 0", bus.stall);
        end
        cycle();
        drive(mk_nop(), 1'b0);
        n_vec++;
        if ({bus.mem_MemRead, bus.mem_MemWrite, bus.mem_Branch, bus.mem_Jump,
             bus.ex_ALUSrc, bus.ex_RegDst, bus.ex_ALUOp, bus.ex_rs, bus.ex_rt} !== 18'd0) begin
            n_bad++;
            $display("FAIL flush_bubble: got %h want 0",
                     {bus.mem_MemRead, bus.mem_MemWrite, bus.mem_Branch, bus.mem_Jump,
                      bus.ex_ALUSrc, bus.ex_RegDst, bus.ex_ALUOp, bus.ex_rs, bus.ex_rt});
        end
    endtask

    task automatic test_random();
        in_t  i;
        logic f;
        logic hold;
        i = '0;
        hold = 1'b0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (!hold) begin
                i = in_t'({$urandom, $urandom});
                i.rs = 5'($urandom_range(0, 3));
                i.rt = 5'($urandom_range(0, 3));
                i.rd = 5'($urandom_range(0, 3));
            end
            f = ($urandom_range(0, 7) == 0);
            RST = ($urandom_range(0, 49) == 0);
            drive(i, f);
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL random cyc%0d: got %h want %h", k, dut_vec(), model_vec());
            end
            hold = load_use() & ~f;
            cycle();
        end
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        test_reset();
        test_load_use();
        test_forward();
        test_priority();
        test_zero_reg();
        test_jal_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
